mp_link_uart: RTL and testbench
===============================

// Module: mp_link_uart
// PURPOSE
// - Multiplayer link between two boards over a 1-wire-per-direction UART (8N1).
// - Sits upstream of the game core: serialises local status (player_ready, game_over, multiplayer)
//   to the opponent board and decodes the opponent's frames into opponent_ready / victory.
// - Sends one status byte on every local status change, plus a periodic heartbeat.
// - Declares the link down when no valid frame arrives within a timeout.
// PARAMETERS
// - CLKS_PER_BIT    6771       clk cycles per UART bit (65 MHz / 9600 Bd); min 8
// - HEARTBEAT_CLKS  6_500_000  cycles between unsolicited status frames (100 ms)
// - TIMEOUT_CLKS    32_500_000 cycles without a valid RX frame before link_up drops (500 ms)
// PORTS
// - clk             in   1  pixel/system clock
// - rst             in   1  synchronous reset, active-high
// - player_ready    in   1  local player waiting in multiplayer lobby
// - game_over       in   1  local player lost
// - multiplayer     in   1  local multiplayer mode active
// - rx              in   1  serial in from opponent, asynchronous, idle high
// - tx              out  1  serial out to opponent, idle high
// - opponent_ready  out  1  opponent's last reported player_ready, gated by link_up
// - victory         out  1  opponent lost while we are still alive in multiplayer (level)
// - link_up         out  1  valid frame seen within last TIMEOUT_CLKS
// BEHAVIOUR
// - Frame payload: [7:4]=4'hA sync, [3]=0, [2]=multiplayer, [1]=game_over, [0]=player_ready.
// - Wire format: LSB first: start(0), 8 data bits, stop(1); each bit held exactly CLKS_PER_BIT cycles.
// - Reset values: tx=1, opponent_ready=0, victory=0, link_up=0; TX and RX FSMs in IDLE; all counters 0.
// - Reset taken mid-frame aborts the frame; tx returns high on the next cycle.
// - TX FSM: IDLE -> START -> DATA(8 bits) -> STOP -> IDLE.
//   - In IDLE, compare the current status {multiplayer, game_over, player_ready} with the last sent value.
//     A mismatch, or heartbeat counter reaching HEARTBEAT_CLKS-1, launches a frame.
//   - Status is latched at launch. Changes during a frame set a pending flag.
//     Pending is honoured in the cycle after STOP, so no change is lost.
//   - Heartbeat counter restarts at every launch.
//   - First frame after reset is sent immediately (last-sent register resets to 3'b111 ^ inputs-impossible
//     marker; use a separate sent_valid=0 flag).
// - RX path:
//   - 2-FF synchroniser on rx.
//   - FSM: IDLE -> START -> DATA -> STOP.
//   - Falling edge in IDLE starts the frame. Sample at CLKS_PER_BIT/2, then every CLKS_PER_BIT.
//   - START sampled high = glitch: back to IDLE, no frame.
//   - Frame valid iff stop sampled 1 AND data[7:3]==5'b10100. Invalid frames are silently dropped.
//   - Valid frame produces a 1-cycle rx_valid with rx_data. Outputs update on the cycle after rx_valid.
// - Link supervision: timeout counter clears on rx_valid. link_up=1 from the cycle after rx_valid.
//   On count == TIMEOUT_CLKS-1, link_up=0 and the stored opponent status clears to 0.
// - opponent_ready = opp_player_ready & link_up.
// - victory:
//   - Set when a valid frame with game_over=1 arrives while multiplayer=1 and local game_over=0.
//   - Cleared when multiplayer=0 or rst.
//   - Holds through a link drop.
//   - Local game_over=1 in the same cycle as the set condition: local loss wins, victory stays 0.
// - Latency, local change -> tx start bit: 1 cycle if TX idle, else after the current stop bit.
// - Arithmetic:
//   - Counters sized $clog2(param).
//   - Bit index is 3 bits; it wraps 7 -> STOP, never back to 0.
// STRUCTURE
// - Shared package mp_link_pkg:
//   - SYNC_NIBBLE=4'hA
//   - payload bit positions (PL_READY=0, PL_GAMEOVER=1, PL_MULTI=2)
//   - TX/RX state encodings (2-bit: IDLE, START, DATA, STOP)
// - Sub-module mp_link_uart_rx: synchroniser, RX FSM and frame check; outputs rx_valid/rx_data.
// - TX FSM, heartbeat, timeout and status registers live in the top.
// TESTING (sim with CLKS_PER_BIT=16, HEARTBEAT_CLKS=2000, TIMEOUT_CLKS=5000; tx looped through a model opponent)
// - Reset release, inputs 0 -> one frame 0xA0 on tx within 1 cycle; 10 bits of 16 clk each; tx=1 after.
// - player_ready 0->1 while TX busy -> current frame completes, next frame 0xA1 starts the cycle after stop.
// - Drive rx with byte 0xA1 -> link_up=1 and opponent_ready=1 one cycle after stop sample.
//   Byte 0x51 (bad sync) -> no change.
// - multiplayer=1, game_over=0, rx byte 0xA6 -> victory=1.
//   Drop multiplayer -> victory=0 next cycle.
//   Repeat with local game_over=1 -> victory stays 0.
// - Stop rx frames after link_up -> exactly 5000 cycles later link_up=0, opponent_ready=0.
// - Assert rst mid-TX data bit 4 -> tx=1 next cycle, all outputs at reset values, fresh frame after release.
//   Also: 4-cycle low glitch on rx -> no rx_valid.

Source files
------------

// File: rtl/mp_link_pkg.sv
// Shared definitions for the two-board multiplayer UART link.
package mp_link_pkg;

    localparam logic [3:0] SYNC_NIBBLE = 4'hA;

    localparam int PL_READY    = 0;
    localparam int PL_GAMEOVER = 1;
    localparam int PL_MULTI    = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    // Status byte: sync nibble, reserved zero, then {multiplayer, game_over, player_ready}.
    function automatic logic [7:0] make_frame(input logic [2:0] status);
        return {SYNC_NIBBLE, 1'b0, status};
    endfunction

endpackage

// File: rtl/mp_link_uart_rx.sv
// Receiver: synchronises rx, decodes 8N1 frames and accepts only well-formed status bytes.
module mp_link_uart_rx
    import mp_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 6771
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       rx_valid,
    output logic [7:0] rx_data
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    uart_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic             rx_p0;
    logic             rx_p1;
    logic             rx_p2;
    logic [7:0]       shift;
    logic             fall;
    logic             bit_end;
    logic             frame_ok;

    assign fall     = rx_p2 & ~rx_p1;
    assign bit_end  = (cnt == BIT_LAST);
    assign frame_ok = (shift[7:3] == {SYNC_NIBBLE, 1'b0});
    assign rx_data  = shift;

    // Two-flop synchroniser plus one extra stage for falling-edge detection; idles high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
            rx_p2 <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_p1 <= rx_p0;
            rx_p2 <= rx_p1;
        end
    end

    // Frame FSM: mid-bit sampling, glitch rejection on start, frame check on stop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (fall) state <= ST_START;
                end
                ST_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_p1 ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) state <= ST_STOP;
                        else                 bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        cnt      <= '0;
                        state    <= ST_IDLE;
                        rx_valid <= rx_p1 & frame_ok;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Data shift register, LSB arrives first.
    always_ff @(posedge clk) begin
        if (state == ST_DATA && bit_end) shift <= {rx_p1, shift[7:1]};
    end

endmodule

// File: rtl/mp_link_uart.sv
// Multiplayer link top: status transmitter with heartbeat, link supervision and opponent status.
module mp_link_uart
    import mp_link_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 6771,
    parameter int HEARTBEAT_CLKS = 6_500_000,
    parameter int TIMEOUT_CLKS   = 32_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic player_ready,
    input  logic game_over,
    input  logic multiplayer,
    input  logic rx,
    output logic tx,
    output logic opponent_ready,
    output logic victory,
    output logic link_up
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int HB_W  = $clog2(HEARTBEAT_CLKS);
    localparam int TO_W  = $clog2(TIMEOUT_CLKS);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [HB_W-1:0]  HB_LAST  = HB_W'(HEARTBEAT_CLKS - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CLKS - 1);

    uart_state_t      tx_state;
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0]       tx_bit;
    logic [7:0]       tx_shift;
    logic [2:0]       last_sent;
    logic             sent_valid;
    logic             pending;
    logic [HB_W-1:0]  hb_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic             opp_ready;
    logic             rx_valid;
    logic [7:0]       rx_data;
    logic [2:0]       status;
    logic             tx_bit_end;
    logic             launch_req;
    logic             do_launch;
    logic             unused_rx_bits;

    assign status     = {multiplayer, game_over, player_ready};
    assign tx_bit_end = (tx_cnt == BIT_LAST);
    assign launch_req = !sent_valid || pending || (status != last_sent) || (hb_cnt == HB_LAST);
    // Launch from IDLE, or straight out of the last stop-bit cycle so back-to-back frames have no gap.
    assign do_launch  = launch_req && ((tx_state == ST_IDLE) || (tx_state == ST_STOP && tx_bit_end));

    assign opponent_ready = opp_ready & link_up;
    assign unused_rx_bits = ^{rx_data[7:3], rx_data[PL_MULTI]};

    mp_link_uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .rx_valid(rx_valid),
        .rx_data (rx_data)
    );

    // TX FSM with heartbeat and change detection; a launch overrides the per-state updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state   <= ST_IDLE;
            tx_cnt     <= '0;
            tx_bit     <= '0;
            tx         <= 1'b1;
            last_sent  <= '0;
            sent_valid <= 1'b0;
            pending    <= 1'b0;
            hb_cnt     <= '0;
        end else begin
            if (hb_cnt != HB_LAST) hb_cnt <= hb_cnt + 1'b1;
            if (tx_state != ST_IDLE && status != last_sent) pending <= 1'b1;
            case (tx_state)
                ST_IDLE: begin
                    tx     <= 1'b1;
                    tx_cnt <= '0;
                end
                ST_START: begin
                    if (tx_bit_end) begin
                        tx_state <= ST_DATA;
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        tx       <= tx_shift[0];
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tx_bit_end) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            tx_state <= ST_STOP;
                            tx       <= 1'b1;
                        end else begin
                            tx_bit <= tx_bit + 1'b1;
                            tx     <= tx_shift[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tx_bit_end) begin
                        tx_state <= ST_IDLE;
                        tx_cnt   <= '0;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
            endcase
            if (do_launch) begin
                tx_state   <= ST_START;
                tx_cnt     <= '0;
                tx         <= 1'b0;
                last_sent  <= status;
                sent_valid <= 1'b1;
                pending    <= 1'b0;
                hb_cnt     <= '0;
            end
        end
    end

    // Outgoing payload: loaded at launch, shifted right as each data bit completes.
    always_ff @(posedge clk) begin
        if (do_launch)                                 tx_shift <= make_frame(status);
        else if (tx_state == ST_DATA && tx_bit_end)    tx_shift <= tx_shift >> 1;
    end

    // Link supervision: valid frames refresh the timeout and the stored opponent status.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt    <= '0;
            link_up   <= 1'b0;
            opp_ready <= 1'b0;
        end else if (rx_valid) begin
            to_cnt    <= '0;
            link_up   <= 1'b1;
            opp_ready <= rx_data[PL_READY];
        end else if (link_up) begin
            if (to_cnt == TO_LAST) begin
                to_cnt    <= '0;
                link_up   <= 1'b0;
                opp_ready <= 1'b0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    // Victory latch: opponent lost while we are alive in multiplayer; survives link drops.
    always_ff @(posedge clk) begin
        if (rst || !multiplayer) begin
            victory <= 1'b0;
        end else if (rx_valid && rx_data[PL_GAMEOVER] && !game_over) begin
            victory <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mp_link_uart.sv
// Directed bench for mp_link_uart with short bit/heartbeat/timeout periods.
module tb_mp_link_uart;

    localparam int CPB = 16;
    localparam int HB  = 2000;
    localparam int TO  = 5000;

    logic clk;
    logic rst;
    logic player_ready;
    logic game_over;
    logic multiplayer;
    logic rx;
    logic tx;
    logic opponent_ready;
    logic victory;
    logic link_up;

    int checks   = 0;
    int failures = 0;
    int run_cur  = 0;
    int run_last = 0;

    logic [7:0] b;
    logic       st;
    logic       sp;
    int         n;
    int         lows;

    mp_link_uart #(
        .CLKS_PER_BIT  (CPB),
        .HEARTBEAT_CLKS(HB),
        .TIMEOUT_CLKS  (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .player_ready  (player_ready),
        .game_over     (game_over),
        .multiplayer   (multiplayer),
        .rx            (rx),
        .tx            (tx),
        .opponent_ready(opponent_ready),
        .victory       (victory),
        .link_up       (link_up)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Length of the most recent continuous link_up interval, in clock cycles.
    always @(posedge clk) begin
        if (link_up === 1'b1) begin
            run_cur <= run_cur + 1;
        end else begin
            if (run_cur != 0) run_last <= run_cur;
            run_cur <= 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Poll tx once per cycle; n = cycles until it is seen low, 0 if never within max.
    task automatic wait_start(input int max, output int cyc);
        int k;
        k   = 0;
        cyc = 0;
        while (cyc == 0 && k < max) begin
            tick();
            k++;
            if (tx === 1'b0) cyc = k;
        end
    endtask

    // Wait until link_up drops, bounded.
    task automatic wait_link_low(input int max);
        int k;
        k = 0;
        while (link_up !== 1'b0 && k < max) begin
            tick();
            k++;
        end
    endtask

    // Called in the first cycle of a start bit; samples every bit at its centre.
    task automatic grab(output logic [7:0] data, output logic start_b, output logic stop_b);
        repeat (CPB / 2 - 1) tick();
        start_b = tx;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) tick();
            data[i] = tx;
        end
        repeat (CPB) tick();
        stop_b = tx;
    endtask

    task automatic send_byte(input logic [7:0] data);
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat (CPB) tick();
        end
        rx = 1'b1;
        repeat (CPB) tick();
    endtask

    initial begin
        rst          = 1'b1;
        player_ready = 1'b0;
        game_over    = 1'b0;
        multiplayer  = 1'b0;
        rx           = 1'b1;
        repeat (4) tick();
        chk("rst_tx", tx, 1);
        chk("rst_link_up", link_up, 0);
        chk("rst_victory", victory, 0);
        chk("rst_opp_ready", opponent_ready, 0);

        rst = 1'b0;
        wait_start(5, n);
        chk("first_latency", n, 1);
        grab(b, st, sp);
        chk("first_start", st, 0);
        chk("first_byte", b, 8'hA0);
        chk("first_stop", sp, 1);
        lows = 0;
        repeat (30) begin
            tick();
            if (tx !== 1'b1) lows++;
        end
        chk("idle_after_first", lows, 0);

        multiplayer = 1'b1;
        wait_start(5, n);
        chk("mp_latency", n, 1);
        player_ready = 1'b1;
        grab(b, st, sp);
        chk("busy_frame", b, 8'hA4);
        wait_start(20, n);
        chk("pending_gap", n, 9);
        grab(b, st, sp);
        chk("pending_frame", b, 8'hA5);
        chk("pending_stop", sp, 1);

        send_byte(8'h51);
        chk("bad_sync_link", link_up, 0);
        send_byte(8'hA1);
        chk("rx_link_up", link_up, 1);
        chk("rx_opp_ready", opponent_ready, 1);
        send_byte(8'h50);
        chk("bad_sync_hold", opponent_ready, 1);
        send_byte(8'hA8);
        chk("bad_bit3_hold", opponent_ready, 1);
        chk("no_victory", victory, 0);

        wait_link_low(6000);
        chk("timeout_drop", link_up, 0);
        repeat (2) tick();
        chk("timeout_len", run_last, TO);
        chk("timeout_opp", opponent_ready, 0);

        send_byte(8'hA6);
        chk("victory_set", victory, 1);
        multiplayer = 1'b0;
        tick();
        chk("victory_clr", victory, 0);
        multiplayer = 1'b1;
        game_over   = 1'b1;
        send_byte(8'hA6);
        chk("victory_local_loss", victory, 0);
        game_over = 1'b0;
        send_byte(8'hA6);
        chk("victory_again", victory, 1);
        wait_link_low(6000);
        chk("link_drop2", link_up, 0);
        chk("victory_hold", victory, 1);

        rx = 1'b0;
        repeat (4) tick();
        rx = 1'b1;
        repeat (20) tick();
        send_byte(8'hA1);
        chk("glitch_link", link_up, 1);
        chk("glitch_opp", opponent_ready, 1);

        player_ready = 1'b0;
        wait_start(300, n);
        chk("pre_reset_launch", (n != 0), 1);
        repeat (CPB * 5 + 4) tick();
        rst = 1'b1;
        tick();
        chk("midtx_rst_tx", tx, 1);
        chk("midtx_rst_link", link_up, 0);
        chk("midtx_rst_opp", opponent_ready, 0);
        chk("midtx_rst_victory", victory, 0);
        repeat (3) tick();
        rst = 1'b0;
        wait_start(5, n);
        chk("post_rst_latency", n, 1);
        grab(b, st, sp);
        chk("post_rst_frame", b, 8'hA4);
        chk("post_rst_stop", sp, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
